aes128_core: RTL and testbench
==============================

Name: aes128_core

Overview:
- Iterative AES-128 encryption engine (FIPS-197, encrypt only): one round per clock, round keys expanded on the fly.
- Accepts a 128-bit key and plaintext on a start pulse, then returns the ciphertext with a one-cycle done pulse.
- Sits as a leaf accelerator behind a bus/control wrapper that drives start/ready.

Parameters:
- None. Key size fixed at 128 bits, Nr fixed at 10.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  start request; accepted only when ready_o=1.
- key_i  input  128  cipher key; bits [127:120] = key byte 0.
- plain_text_i  input  128  plaintext block; bits [127:120] = byte 0. Loaded into the FIPS column-major state, byte n -> row n%4, column n/4.
- cipher_text_o  output  128  ciphertext, same byte ordering; registered.
- ready_o  output  1  high when idle and able to accept start_i.
- done_o  output  1  one-cycle pulse when cipher_text_o becomes valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - FSM = IDLE; ready_o=1; done_o=0; cipher_text_o=0.
  - Internal state, round key and round counter all 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - ready_o = 1.
  - When start_i=1 at a rising edge:
    - state <= plain_text_i ^ key_i (initial AddRoundKey);
    - round_key <= key_i;
    - round <= 1;
    - go to BUSY.
  - key_i and plain_text_i are sampled only at this edge; they may change afterwards.
- BUSY:
  - ready_o = 0.
  - Each edge computes round_key_next = KeyExpand(round_key, Rcon[round]) combinationally, then registers:
    - state <= SubBytes -> ShiftRows -> MixColumns -> AddRoundKey(round_key_next);
    - round_key <= round_key_next;
    - round <= round + 1.
  - Round 10 omits MixColumns.
  - On the round-10 edge:
    - cipher_text_o <= result;
    - done_o <= 1 for exactly one cycle;
    - return to IDLE.
- Latency: start accepted at edge N -> cipher_text_o valid and done_o=1 after edge N+10. A new start is accepted at edge N+11 at the earliest. Throughput is one block per 11 cycles.
- cipher_text_o holds its value until the next completion. It is not cleared by a new start.
- start_i asserted while BUSY is ignored (no queueing, no effect on the current operation).
- Key schedule: RotWord, SubWord and Rcon are applied to word 3. Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- MixColumns uses xtime (shift left, conditional xor 0x1b) over GF(2^8).
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and done_o is never issued for the aborted block.
- No back-pressure: done_o is a pulse, not a handshake.

Optional Feature:
- AES128_CORE_ZEROIZE_EN defined:
  - On the completion edge, internal state and round_key registers are cleared to 0, so no key material remains after use.
  - cipher_text_o is unaffected.
- Not defined: internal registers retain the last round's values until the next start.
- Interface and latency are identical in both cases.

Decomposition:
- Package aes_pkg holds:
  - typedefs: byte_t; state_t (4x4 byte array); word_t;
  - constants: SBOX[256] table, RCON[10];
  - functions: xtime, sub_word, rot_word, shift_rows, mix_columns, key_expand_step.
- Sub-module aes_sbox: combinational 8-bit S-box lookup. Instantiated 16x for SubBytes and 4x for SubWord.
- The core contains the FSM, datapath registers and round counter.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cipher 69c4e0d86a7b0430d8cdb78070b4c55a; done_o exactly one cycle, 10 cycles after the start edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e; then back-to-back start at the first ready cycle with the C.1 vector -> correct second result, ready_o low for exactly 10 cycles each.
- Start the C.1 vector, hold start_i=1 and change key_i/plain_text_i during BUSY -> C.1 result unchanged, single done_o pulse.
- Assert rst_n=0 at round 5 -> cipher_text_o=0, done_o=0, ready_o=1; with no new start, done_o never pulses.
- With AES128_CORE_ZEROIZE_EN defined: after done_o, internal state and round_key read 0 while cipher_text_o holds the C.1 result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and round helpers used by the core and the S-box.
// state_t is indexed [3-col][3-row], which puts byte 0 (row 0, col 0) in bits [127:120].
package aes_pkg;

    typedef logic [7:0]             byte_t;
    typedef logic [31:0]            word_t;
    typedef logic [3:0][3:0][7:0]   state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[2'(3 - c)][2'(3 - r)] = s[2'(3 - ((c + r) % 4))][2'(3 - r)];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        byte_t  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[2'(3 - c)][3];
            a1 = s[2'(3 - c)][2];
            a2 = s[2'(3 - c)][1];
            a3 = s[2'(3 - c)][0];
            o[2'(3 - c)][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[2'(3 - c)][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[2'(3 - c)][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[2'(3 - c)][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // sw is SubWord(RotWord(word 3)), supplied by the caller's S-box instances.
    function automatic logic [127:0] key_expand_step(input logic [127:0] k, input word_t sw,
                                                     input byte_t rc);
        word_t w0, w1, w2, w3;
        w0 = k[127:96] ^ sw ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_core.sv
// Iterative AES-128 encrypt core: one round per clock, key schedule computed alongside.
// Optional macro AES128_CORE_ZEROIZE_EN clears state and round key on completion.
module aes128_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] plain_text_i,
    output logic [127:0] cipher_text_o,
    output logic         ready_o,
    output logic         done_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]   r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_round_key;
    logic [127:0] r_cipher;
    logic [3:0]   r_round;
    logic         r_done;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_next_key;
    logic [127:0] w_next_state;
    word_t        w_rot;
    word_t        w_sub_word;
    byte_t        w_rcon;
    logic         w_last;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub_bytes
            aes_sbox u_sbox (
                .i_byte (r_state[127 - 8*gi -: 8]),
                .o_byte (w_sub[127 - 8*gi -: 8])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            aes_sbox u_sbox (
                .i_byte (w_rot[31 - 8*gi -: 8]),
                .o_byte (w_sub_word[31 - 8*gi -: 8])
            );
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        if (r_round != 4'd0 && r_round <= 4'd10) begin
            w_rcon = RCON[r_round - 4'd1];
        end
    end

    assign w_rot        = rot_word(r_round_key[31:0]);
    assign w_next_key   = key_expand_step(r_round_key, w_sub_word, w_rcon);
    assign w_shift      = shift_rows(w_sub);
    assign w_mix        = mix_columns(w_shift);
    assign w_last       = (r_round == 4'd10);
    assign w_next_state = (w_last ? w_shift : w_mix) ^ w_next_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_round_key <= '0;
            r_cipher    <= '0;
            r_round     <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_fsm == ST_IDLE) begin
                if (start_i) begin
                    r_state     <= plain_text_i ^ key_i;
                    r_round_key <= key_i;
                    r_round     <= 4'd1;
                    r_fsm       <= ST_BUSY;
                end
            end else begin
                r_state     <= w_next_state;
                r_round_key <= w_next_key;
                r_round     <= r_round + 4'd1;
                if (w_last) begin
                    r_cipher <= w_next_state;
                    r_done   <= 1'b1;
                    r_round  <= 4'd0;
                    r_fsm    <= ST_IDLE;
`ifdef AES128_CORE_ZEROIZE_EN
                    r_state     <= '0;
                    r_round_key <= '0;
`endif
                end
            end
        end
    end

    assign cipher_text_o = r_cipher;
    assign ready_o       = (r_fsm == ST_IDLE);
    assign done_o        = r_done;

endmodule

// File: tb/tb_aes128_core.sv
// Directed-vector bench for aes128_core using FIPS-197 known answers.
// Define AES128_CORE_ZEROIZE_EN to also check the register clearing after completion.
module tb_aes128_core;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic [127:0] plain_text_i;
    logic [127:0] cipher_text_o;
    logic         ready_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .key_i         (key_i),
        .plain_text_i  (plain_text_i),
        .cipher_text_o (cipher_text_o),
        .ready_o       (ready_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start and observes the 10 following edges; leaves time at #1 after the done edge.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input bit hold,
                             output logic [127:0] ct, output int done_cnt, output int done_at,
                             output int ready_low);
        done_cnt  = 0;
        done_at   = 0;
        ready_low = 0;
        start_i      = 1'b1;
        key_i        = key;
        plain_text_i = pt;
        @(posedge clk);
        #1;
        if (!ready_o) ready_low++;
        if (done_o) done_cnt++;
        if (!hold) start_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (hold) begin
                key_i        = {$urandom, $urandom, $urandom, $urandom};
                plain_text_i = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            #1;
            if (!ready_o) ready_low++;
            if (done_o) begin
                done_cnt++;
                done_at = k;
            end
        end
        ct = cipher_text_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; key_i = '0; plain_text_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++;
        if (cipher_text_o !== 128'h0) begin errors++; $display("FAIL reset_cipher: got %h expected 0", cipher_text_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released: ready=%b done=%b ct=%h", ready_o, done_o, cipher_text_o);
    endtask

    task automatic test_fips_c1();
        logic [127:0] ct; int dc, da, rl;
        run_block(C1_KEY, C1_PT, 1'b0, ct, dc, da, rl);
        $display("c1: ct=%h done_cnt=%0d done_at=%0d ready_low=%0d", ct, dc, da, rl);
        checks++;
        if (ct !== C1_CT) begin errors++; $display("FAIL c1_cipher: got %h expected %h", ct, C1_CT); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL c1_done_count: got %0d expected 1", dc); end
        checks++;
        if (da != 10) begin errors++; $display("FAIL c1_done_latency: got %0d expected 10", da); end
        checks++;
        if (rl != 10) begin errors++; $display("FAIL c1_ready_low: got %0d expected 10", rl); end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL c1_done_width: got %b expected 0", done_o); end
        checks++;
        if (cipher_text_o !== C1_CT) begin errors++; $display("FAIL c1_cipher_hold: got %h expected %h", cipher_text_o, C1_CT); end
    endtask

    task automatic test_fips_b();
        logic [127:0] ct; int dc, da, rl;
        run_block(B_KEY, B_PT, 1'b0, ct, dc, da, rl);
        $display("appB: ct=%h done_cnt=%0d done_at=%0d", ct, dc, da);
        checks++;
        if (ct !== B_CT) begin errors++; $display("FAIL b_cipher: got %h expected %h", ct, B_CT); end
        checks++;
        if (dc != 1 || da != 10) begin errors++; $display("FAIL b_done: got cnt=%0d at=%0d expected cnt=1 at=10", dc, da); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct; int dc, da, rl;
        run_block(128'h0, 128'h0, 1'b0, ct, dc, da, rl);
        $display("zero: ct=%h done_cnt=%0d ready_low=%0d", ct, dc, rl);
        checks++;
        if (ct !== Z_CT) begin errors++; $display("FAIL zero_cipher: got %h expected %h", ct, Z_CT); end
        checks++;
        if (rl != 10) begin errors++; $display("FAIL zero_ready_low: got %0d expected 10", rl); end
        run_block(C1_KEY, C1_PT, 1'b0, ct, dc, da, rl);
        $display("b2b c1: ct=%h done_cnt=%0d done_at=%0d ready_low=%0d", ct, dc, da, rl);
        checks++;
        if (ct !== C1_CT) begin errors++; $display("FAIL b2b_cipher: got %h expected %h", ct, C1_CT); end
        checks++;
        if (rl != 10) begin errors++; $display("FAIL b2b_ready_low: got %0d expected 10", rl); end
        checks++;
        if (dc != 1 || da != 10) begin errors++; $display("FAIL b2b_done: got cnt=%0d at=%0d expected cnt=1 at=10", dc, da); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_start_ignored();
        logic [127:0] ct; int dc, da, rl;
        run_block(C1_KEY, C1_PT, 1'b1, ct, dc, da, rl);
        start_i = 1'b0;
        $display("hold: ct=%h done_cnt=%0d done_at=%0d", ct, dc, da);
        checks++;
        if (ct !== C1_CT) begin errors++; $display("FAIL hold_cipher: got %h expected %h", ct, C1_CT); end
        checks++;
        if (dc != 1 || da != 10) begin errors++; $display("FAIL hold_done: got cnt=%0d at=%0d expected cnt=1 at=10", dc, da); end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL hold_after: got done=%b ready=%b expected done=0 ready=1", done_o, ready_o);
        end
    endtask

    task automatic test_zeroize();
`ifdef AES128_CORE_ZEROIZE_EN
        logic [127:0] ct; int dc, da, rl;
        run_block(C1_KEY, C1_PT, 1'b0, ct, dc, da, rl);
        $display("zeroize: ct=%h state=%h round_key=%h", ct, dut.r_state, dut.r_round_key);
        checks++;
        if (dut.r_state !== 128'h0) begin errors++; $display("FAIL zeroize_state: got %h expected 0", dut.r_state); end
        checks++;
        if (dut.r_round_key !== 128'h0) begin errors++; $display("FAIL zeroize_key: got %h expected 0", dut.r_round_key); end
        checks++;
        if (cipher_text_o !== C1_CT) begin errors++; $display("FAIL zeroize_cipher: got %h expected %h", cipher_text_o, C1_CT); end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        pulses = 0;
        start_i = 1'b1; key_i = C1_KEY; plain_text_i = C1_PT;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("mid reset: ct=%h done=%b ready=%b", cipher_text_o, done_o, ready_o);
        checks++;
        if (cipher_text_o !== 128'h0) begin errors++; $display("FAIL midrst_cipher: got %h expected 0", cipher_text_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
        checks++;
        if (cipher_text_o !== 128'h0) begin errors++; $display("FAIL midrst_cipher_after: got %h expected 0", cipher_text_o); end
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_back_to_back();
        test_busy_start_ignored();
        test_zeroize();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
